// File: rtl/memory_access.sv
// -----------------------------------------------------------------------------
// memory_access -- memory stage of the in-order pipeline.
//
// Receives the registered execute-stage bundle, performs loads/stores over a
// request/acknowledge data bus, aligns and extends load data, flags misaligned
// accesses and forwards the control bundle to writeback.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   *_in (pipeline bundle)     PC/next PC, ALU result (effective address),
//                              store data, CSR data, control flags, size,
//                              writeback select, rd/CSR addresses, valid,
//                              exception flag and cause
//   stall, invalidate          hazard-unit controls
//   mem_busy                   high while a bus access is outstanding
//   mem_req/we/addr/wdata/strobe  bus request side (registered)
//   mem_ack, mem_rdata         bus completion and read data
//   *_out (writeback bundle)   registered results; valid_out pulses for one
//                              cycle per completed instruction
//
// Optional feature
//   MEM_BUS_ERROR_EN  adds input mem_err, sampled with mem_ack; an errored
//                     completion reports exception cause 5 (load) / 7 (store).
// -----------------------------------------------------------------------------
module memory_access (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic [31:0] next_pc_in,
    input  logic [31:0] alu_data_in,
    input  logic [31:0] rs2_data_in,
    input  logic [31:0] csr_data_in,
    input  logic        branch_taken_in,
    input  logic        load_in,
    input  logic        store_in,
    input  logic        load_signed_in,
    input  logic        csr_write_in,
    input  logic        mret_in,
    input  logic        wfi_in,
    input  logic [1:0]  load_store_size_in,
    input  logic [1:0]  write_select_in,
    input  logic [4:0]  rd_address_in,
    input  logic [11:0] csr_address_in,
    input  logic        valid_in,
    input  logic        exception_in,
    input  logic [3:0]  ecause_in,
    input  logic        stall,
    input  logic        invalidate,
    output logic        mem_busy,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_strobe,
    input  logic        mem_ack,
`ifdef MEM_BUS_ERROR_EN
    input  logic        mem_err,
`endif
    input  logic [31:0] mem_rdata,
    output logic [31:0] pc_out,
    output logic [31:0] next_pc_out,
    output logic [31:0] alu_data_out,
    output logic [31:0] csr_data_out,
    output logic [31:0] load_data_out,
    output logic        branch_taken_out,
    output logic        csr_write_out,
    output logic        mret_out,
    output logic        wfi_out,
    output logic        valid_out,
    output logic        exception_out,
    output logic [1:0]  write_select_out,
    output logic [4:0]  rd_address_out,
    output logic [11:0] csr_address_out,
    output logic [3:0]  ecause_out
);

    typedef enum logic [0:0] {IDLE, ACCESS} state_t;

    // Fields that travel unchanged to writeback.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] next_pc;
        logic [31:0] alu;
        logic [31:0] csr_data;
        logic        branch_taken;
        logic        csr_write;
        logic        mret;
        logic        wfi;
        logic [1:0]  write_select;
        logic [4:0]  rd;
        logic [11:0] csr_addr;
    } wb_t;

    state_t      state_q, state_d;

    // Instruction held while the bus access is outstanding
    wb_t         acc_wb_q, acc_wb_d;
    logic        acc_load_q, acc_load_d;
    logic        acc_signed_q, acc_signed_d;
    logic [1:0]  acc_size_q, acc_size_d;
    logic [3:0]  acc_ecause_q, acc_ecause_d;
    logic        kill_q, kill_d;

    // Bus request registers
    logic        mem_req_q, mem_req_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [3:0]  mem_strobe_q, mem_strobe_d;

    // Writeback output registers
    wb_t         out_wb_q, out_wb_d;
    logic        exc_q, exc_d;
    logic [3:0]  ecause_q, ecause_d;
    logic [31:0] ld_q, ld_d;
    logic        valid_q, valid_d;

    wb_t         wb_in;
    logic        bus_err;
    logic        accept;
    logic        is_mem_in;
    logic        misaligned_in;
    logic        pass_now;
    logic        start_bus;
    logic        ack_done;

`ifdef MEM_BUS_ERROR_EN
    assign bus_err = mem_err;
`else
    assign bus_err = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic [3:0] strobe_of(input logic [1:0] size,
                                             input logic [1:0] off);
        logic [3:0] s;
        case (size)
            2'd0:    s = 4'b0001 << off;
            2'd1:    s = off[1] ? 4'b1100 : 4'b0011;
            default: s = 4'b1111;
        endcase
        return s;
    endfunction

    function automatic logic [31:0] wdata_of(input logic [1:0]  size,
                                             input logic [31:0] d);
        logic [31:0] w;
        case (size)
            2'd0:    w = {4{d[7:0]}};
            2'd1:    w = {2{d[15:0]}};
            default: w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] extract(input logic [31:0] rdata,
                                            input logic [1:0]  off,
                                            input logic [1:0]  size,
                                            input logic        sgn);
        logic [31:0] s;
        logic [31:0] r;
        s = rdata >> {off, 3'b000};
        case (size)
            2'd0:    r = {{24{sgn & s[7]}}, s[7:0]};
            2'd1:    r = {{16{sgn & s[15]}}, s[15:0]};
            default: r = s;
        endcase
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Decode of the incoming instruction
    // ------------------------------------------------------------------
    always_comb begin
        wb_in              = '0;
        wb_in.pc           = pc_in;
        wb_in.next_pc      = next_pc_in;
        wb_in.alu          = alu_data_in;
        wb_in.csr_data     = csr_data_in;
        wb_in.branch_taken = branch_taken_in;
        wb_in.csr_write    = csr_write_in;
        wb_in.mret         = mret_in;
        wb_in.wfi          = wfi_in;
        wb_in.write_select = write_select_in;
        wb_in.rd           = rd_address_in;
        wb_in.csr_addr     = csr_address_in;
    end

    assign accept        = (state_q == IDLE) && valid_in && !stall && !invalidate;
    assign is_mem_in     = load_in | store_in;
    assign misaligned_in = ((load_store_size_in == 2'd1) && alu_data_in[0]) ||
                           (load_store_size_in[1] && (alu_data_in[1:0] != 2'b00));
    // Upstream exceptions take precedence over alignment checking.
    assign pass_now      = accept && (!is_mem_in || exception_in || misaligned_in);
    assign start_bus     = accept && is_mem_in && !exception_in && !misaligned_in;
    assign ack_done      = (state_q == ACCESS) && mem_ack;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_bus) state_d = ACCESS;
            ACCESS:  if (mem_ack)   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        mem_busy = (state_q == ACCESS);
    end

    // ------------------------------------------------------------------
    // Datapath next-state
    // ------------------------------------------------------------------
    always_comb begin
        acc_wb_d     = acc_wb_q;
        acc_load_d   = acc_load_q;
        acc_signed_d = acc_signed_q;
        acc_size_d   = acc_size_q;
        acc_ecause_d = acc_ecause_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_strobe_d = mem_strobe_q;
        out_wb_d     = out_wb_q;
        exc_d        = exc_q;
        ecause_d     = ecause_q;
        ld_d         = ld_q;
        valid_d      = 1'b0;
        // A kill seen at any point of the access suppresses its completion.
        kill_d       = (state_q == ACCESS) ? (kill_q | invalidate) : 1'b0;

        if (pass_now) begin
            out_wb_d = wb_in;
            ld_d     = '0;
            valid_d  = 1'b1;
            if (!exception_in && misaligned_in) begin
                exc_d    = 1'b1;
                ecause_d = load_in ? 4'd4 : 4'd6;
            end else begin
                exc_d    = exception_in;
                ecause_d = ecause_in;
            end
        end

        if (start_bus) begin
            acc_wb_d     = wb_in;
            acc_load_d   = load_in;
            acc_signed_d = load_signed_in;
            acc_size_d   = load_store_size_in;
            acc_ecause_d = ecause_in;
            mem_req_d    = 1'b1;
            mem_we_d     = store_in;
            mem_addr_d   = {alu_data_in[31:2], 2'b00};
            mem_wdata_d  = wdata_of(load_store_size_in, rs2_data_in);
            mem_strobe_d = strobe_of(load_store_size_in, alu_data_in[1:0]);
        end

        if (ack_done) begin
            mem_req_d = 1'b0;
            out_wb_d  = acc_wb_q;
            valid_d   = !(kill_q | invalidate);
            if (bus_err) begin
                exc_d    = 1'b1;
                ecause_d = acc_load_q ? 4'd5 : 4'd7;
                ld_d     = '0;
            end else begin
                exc_d    = 1'b0;
                ecause_d = acc_ecause_q;
                ld_d     = acc_load_q ? extract(mem_rdata, acc_wb_q.alu[1:0],
                                                acc_size_q, acc_signed_q)
                                      : '0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_wb_q     <= '0;
            acc_load_q   <= 1'b0;
            acc_signed_q <= 1'b0;
            acc_size_q   <= '0;
            acc_ecause_q <= '0;
            kill_q       <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_strobe_q <= '0;
            out_wb_q     <= '0;
            exc_q        <= 1'b0;
            ecause_q     <= '0;
            ld_q         <= '0;
            valid_q      <= 1'b0;
        end else begin
            acc_wb_q     <= acc_wb_d;
            acc_load_q   <= acc_load_d;
            acc_signed_q <= acc_signed_d;
            acc_size_q   <= acc_size_d;
            acc_ecause_q <= acc_ecause_d;
            kill_q       <= kill_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_strobe_q <= mem_strobe_d;
            out_wb_q     <= out_wb_d;
            exc_q        <= exc_d;
            ecause_q     <= ecause_d;
            ld_q         <= ld_d;
            valid_q      <= valid_d;
        end
    end

    assign mem_req          = mem_req_q;
    assign mem_we           = mem_we_q;
    assign mem_addr         = mem_addr_q;
    assign mem_wdata        = mem_wdata_q;
    assign mem_strobe       = mem_strobe_q;

    assign pc_out           = out_wb_q.pc;
    assign next_pc_out      = out_wb_q.next_pc;
    assign alu_data_out     = out_wb_q.alu;
    assign csr_data_out     = out_wb_q.csr_data;
    assign branch_taken_out = out_wb_q.branch_taken;
    assign csr_write_out    = out_wb_q.csr_write;
    assign mret_out         = out_wb_q.mret;
    assign wfi_out          = out_wb_q.wfi;
    assign write_select_out = out_wb_q.write_select;
    assign rd_address_out   = out_wb_q.rd;
    assign csr_address_out  = out_wb_q.csr_addr;
    assign load_data_out    = ld_q;
    assign exception_out    = exc_q;
    assign ecause_out       = ecause_q;
    assign valid_out        = valid_q;

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- Memory stage of the in-order pipeline: the receiving end of the execute→memory interface.
- Accepts execute's registered outputs and performs the load/store on a request/acknowledge data bus.
- Aligns and extends load data, detects misaligned accesses, and forwards the control bundle to writeback.
- Signals the hazard unit while a bus access is outstanding.

Parameters:
none

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pc_in, next_pc_in  in  32 each  instruction PC / successor PC
alu_data_in  in  32  ALU result; effective address for loads/stores
rs2_data_in  in  32  store data
csr_data_in  in  32  CSR read value
branch_taken_in, load_in, store_in, load_signed_in, csr_write_in, mret_in, wfi_in  in  1 each  control
load_store_size_in  in  2  0 byte, 1 half, 2/3 word
write_select_in  in  2  writeback source select
rd_address_in  in  5  destination register
csr_address_in  in  12  CSR address
valid_in, exception_in  in  1 each; ecause_in  in  4  validity and trap info
stall, invalidate  in  1 each  from hazard
mem_busy  out  1  to hazard; high while in ACCESS
mem_req, mem_we  out  1 each  bus request / write enable
mem_addr  out  32  word-aligned address ({alu[31:2],2'b00})
mem_wdata  out  32; mem_strobe  out  4  replicated store data, byte enables
mem_ack  in  1; mem_rdata  in  32  bus completion, read data
pc_out, next_pc_out, alu_data_out, csr_data_out, load_data_out  out  32 each  to writeback
branch_taken_out, csr_write_out, mret_out, wfi_out, valid_out, exception_out  out  1 each
write_select_out  out  2; rd_address_out  out  5; csr_address_out  out  12; ecause_out  out  4

Behaviour:
- Reset (async, rst_n=0):
  - All outputs are 0.
  - FSM goes to IDLE.
  - mem_req drops immediately, including mid-access; the outstanding access is abandoned.
- valid_out defaults to 0 every cycle; it is 1 only in the cycle after an instruction completes.
- IDLE, instruction accepted when valid_in && !stall && !invalidate:
  - Capture all *_in fields.
  - Non-memory op, or exception_in set: complete next cycle with fields passed through; ecause/exception passed unchanged; no bus activity.
  - Misaligned access (half with addr[0]=1, word with addr[1:0]≠0), exception_in=0: complete next cycle with exception_out=1, ecause_out=4 (load) or 6 (store); no bus activity.
  - Aligned load/store: next cycle mem_req=1, mem_we=store, addr/wdata/strobe registered; FSM moves to ACCESS.
- ACCESS:
  - mem_busy=1.
  - mem_req and all bus outputs held stable until mem_ack.
  - At the edge where mem_ack=1: mem_req←0, outputs loaded, valid_out←1 (0 if the access was killed), FSM→IDLE. Total latency = ack wait + 2 cycles.
  - stall has no effect in ACCESS.
- invalidate during ACCESS: the bus access is not aborted; the kill is remembered, and completion produces valid_out=0.
- Strobes:
  - byte: 1<<addr[1:0]
  - half: 0011 / 1100
  - word: 1111
- wdata:
  - byte: {4{rs2[7:0]}}
  - half: {2{rs2[15:0]}}
  - word: rs2
- Loads also drive the strobe.
- load_data_out: mem_rdata>>(8*addr[1:0]), truncated to size, then sign- (load_signed) or zero-extended; 0 for non-loads.
- mem_ack seen while in IDLE is ignored.

Optional Feature:
- MEM_BUS_ERROR_EN:
  - Adds input mem_err (1), sampled with mem_ack.
  - mem_err=1 at completion gives exception_out=1 and ecause_out=5 (load) or 7 (store); load_data_out=0.
  - Without the macro the port does not exist and every ack is a successful completion.

Test Plan:
- Load byte signed, addr 0x00001003, mem_rdata 0x80FF0000, ack after 3 wait cycles → mem_addr 0x00001000, strobe 1000, mem_busy high 4 cycles, load_data_out 0xFFFFFF80, valid_out pulse 1 cycle.
- Store half, addr 0x00002002, rs2 0x1234ABCD → mem_we=1, mem_wdata 0xABCDABCD, strobe 1100; on ack valid_out=1, exception_out=0.
- Word load at 0x00001002 → mem_req never asserted; next cycle exception_out=1, ecause_out=4, valid_out=1.
- Non-memory op, alu_data_in 0x55, rd 7 → next cycle valid_out=1, alu_data_out 0x55, rd_address_out 7; with stall=1 instead → valid_out=0.
- invalidate asserted in ACCESS before ack → mem_req stays high until ack; completion valid_out=0; next instruction accepted normally.
- rst_n pulsed low during ACCESS → mem_req/mem_busy/valid_out 0 immediately; after release the FSM is IDLE and accepts a new load.
